// File: rtl/hazard_pkg.sv
// Shared types for the pipeline forwarding/hazard controller: bypass select codes,
// controller states and the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_HOLD = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } haz_state_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// One EX source port's bypass priority compare: MEM over WB over hold register over regfile.
module hazard_fwd_cmp
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_regwrite,
  input  logic          hold_valid,
  input  logic [AW-1:0] hold_rd,
  output logic [1:0]    sel
);

  logic     rs_live_s;
  fwd_sel_e sel_s;

  assign rs_live_s = (rs != AW'(REG_ZERO));

  // Youngest in-flight producer of the register wins
  always_comb begin
    sel_s = FWD_RF;
    if (rs_live_s && mem_regwrite && (mem_rd == rs)) begin
      sel_s = FWD_MEM;
    end else if (rs_live_s && wb_regwrite && (wb_rd == rs)) begin
      sel_s = FWD_WB;
    end else if (rs_live_s && hold_valid && (hold_rd == rs)) begin
      sel_s = FWD_HOLD;
    end else begin
      sel_s = FWD_RF;
    end
  end

  assign sel = sel_s;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding + hazard controller for the 5-stage RV32 pipeline.
// Optional HAZARD_PERF_CNT_EN adds stall/forward cycle counters.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_RS   = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RS*AW-1:0] id_rs,
  input  logic [NUM_RS-1:0]    id_rs_used,
  input  logic [NUM_RS*AW-1:0] ex_rs,
  input  logic [AW-1:0]        ex_rd,
  input  logic                 ex_regwrite,
  input  logic                 ex_memread,
  input  logic [AW-1:0]        mem_rd,
  input  logic                 mem_regwrite,
  input  logic                 mem_memread,
  input  logic                 mem_memwrite,
  input  logic [AW-1:0]        mem_rs2,
  input  logic                 mem_ready,
  input  logic [AW-1:0]        wb_rd,
  input  logic                 wb_regwrite,
  output logic [NUM_RS*2-1:0]  fwd_sel,
  output logic                 store_fwd,
  output logic                 hold_we,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_mem,
  output logic                 bubble_ex,
  output logic                 bubble_wb
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_fwd_cnt
`endif
);

  localparam logic [2:0] LU_RELOAD = 3'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);

  haz_state_e           state_r, state_nxt_s, ret_state_r, ret_state_nxt_s;
  logic [2:0]           lu_cnt_r, lu_cnt_nxt_s;
  logic                 hold_valid_r;
  logic [AW-1:0]        hold_rd_r;
  logic [NUM_RS*2-1:0]  fwd_raw_s;
  logic                 rs_hit_s, lu_hazard_s, mem_wait_s;
  logic                 stall_if_s, stall_id_s, stall_ex_s, stall_mem_s, bubble_ex_s, bubble_wb_s;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_cmp
    hazard_fwd_cmp #(.AW(AW)) u_cmp (
      .rs          (ex_rs[i*AW +: AW]),
      .mem_rd      (mem_rd),
      .mem_regwrite(mem_regwrite),
      .wb_rd       (wb_rd),
      .wb_regwrite (wb_regwrite),
      .hold_valid  (hold_valid_r),
      .hold_rd     (hold_rd_r),
      .sel         (fwd_raw_s[i*2 +: 2])
    );
  end

  // Does any used ID source read the register the EX load is producing
  always_comb begin
    rs_hit_s = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (id_rs_used[i] && (id_rs[i*AW +: AW] == ex_rd)) begin
        rs_hit_s = 1'b1;
      end else begin
        rs_hit_s = rs_hit_s;
      end
    end
  end

  assign lu_hazard_s = ex_memread && ex_regwrite && (ex_rd != AW'(REG_ZERO)) && rs_hit_s;
  assign mem_wait_s  = (mem_memread || mem_memwrite) && !mem_ready;

  // Stall controller next state and stage controls
  always_comb begin
    state_nxt_s     = state_r;
    ret_state_nxt_s = ret_state_r;
    lu_cnt_nxt_s    = lu_cnt_r;
    stall_if_s      = 1'b0;
    stall_id_s      = 1'b0;
    stall_ex_s      = 1'b0;
    stall_mem_s     = 1'b0;
    bubble_ex_s     = 1'b0;
    bubble_wb_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (mem_wait_s) begin
          state_nxt_s     = MEM_WAIT;
          ret_state_nxt_s = RUN;
        end else if (lu_hazard_s) begin
          stall_if_s  = 1'b1;
          stall_id_s  = 1'b1;
          bubble_ex_s = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nxt_s  = LU_STALL;
            lu_cnt_nxt_s = LU_RELOAD;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      LU_STALL: begin
        stall_if_s  = 1'b1;
        stall_id_s  = 1'b1;
        bubble_ex_s = 1'b1;
        // A memory wait freezes the remaining bubble count until it resolves
        if (mem_wait_s) begin
          state_nxt_s     = MEM_WAIT;
          ret_state_nxt_s = LU_STALL;
        end else if (lu_cnt_r == 3'd0) begin
          state_nxt_s = RUN;
        end else begin
          lu_cnt_nxt_s = lu_cnt_r - 3'd1;
        end
      end
      MEM_WAIT: begin
        stall_if_s  = 1'b1;
        stall_id_s  = 1'b1;
        stall_ex_s  = 1'b1;
        stall_mem_s = 1'b1;
        bubble_wb_s = 1'b1;
        if (mem_ready) begin
          state_nxt_s = ret_state_r;
        end else begin
          state_nxt_s = MEM_WAIT;
        end
      end
      default: begin
        state_nxt_s     = RUN;
        ret_state_nxt_s = RUN;
        lu_cnt_nxt_s    = 3'd0;
      end
    endcase
  end

  // Controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      ret_state_r <= RUN;
      lu_cnt_r    <= 3'd0;
    end else begin
      state_r     <= state_nxt_s;
      ret_state_r <= ret_state_nxt_s;
      lu_cnt_r    <= lu_cnt_nxt_s;
    end
  end

  assign stall_if  = !rst && stall_if_s;
  assign stall_id  = !rst && stall_id_s;
  assign stall_ex  = !rst && stall_ex_s;
  assign stall_mem = !rst && stall_mem_s;
  assign bubble_ex = !rst && bubble_ex_s;
  assign bubble_wb = !rst && bubble_wb_s;
  assign hold_we   = !rst && stall_ex_s && wb_regwrite && (wb_rd != AW'(REG_ZERO));
  assign store_fwd = !rst && wb_regwrite && mem_memwrite && (wb_rd == mem_rs2)
                     && (mem_rs2 != AW'(REG_ZERO));
  assign fwd_sel   = rst ? '0 : fwd_raw_s;

  // Retired write held while EX is frozen, dropped once EX moves again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_r <= 1'b0;
      hold_rd_r    <= '0;
    end else if (hold_we) begin
      hold_valid_r <= 1'b1;
      hold_rd_r    <= wb_rd;
    end else if (!stall_ex) begin
      hold_valid_r <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running cycle counters, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_fwd_cnt   <= 32'd0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, stall_if};
      perf_fwd_cnt   <= perf_fwd_cnt + {31'd0, (|fwd_sel)};
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a bubble-count/wait-flag reference model.
module tb_hazard_fwd_ctrl;

  localparam int NUM_RS   = 2;
  localparam int AW       = 5;
  localparam int LOAD_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_RS*AW-1:0] id_rs, ex_rs;
  logic [NUM_RS-1:0]    id_rs_used;
  logic [AW-1:0]        ex_rd, mem_rd, mem_rs2, wb_rd;
  logic ex_regwrite, ex_memread, mem_regwrite, mem_memread, mem_memwrite, mem_ready, wb_regwrite;
  logic [NUM_RS*2-1:0]  fwd_sel;
  logic store_fwd, hold_we, stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_fwd_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  hazard_fwd_ctrl #(.NUM_RS(NUM_RS), .AW(AW), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_rs2(mem_rs2), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .fwd_sel(fwd_sel), .store_fwd(store_fwd),
    .hold_we(hold_we), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .bubble_ex(bubble_ex), .bubble_wb(bubble_wb)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: remaining load-use bubbles, memory-wait flag, held register
  int            m_lu_left;
  bit            m_wait;
  bit            m_hv;
  logic [AW-1:0] m_hr;

  logic [NUM_RS*2-1:0] e_fwd;
  logic e_store, e_hold_we, e_sif, e_sid, e_sex, e_smem, e_bex, e_bwb;
  bit   e_haz, mem_busy;

  function automatic logic [1:0] fwd_code(input logic [AW-1:0] r, input bit mrw,
      input logic [AW-1:0] mrd, input bit wrw, input logic [AW-1:0] wrd,
      input bit hv, input logic [AW-1:0] hr);
    if (r == '0) return 2'b00;
    if (mrw && mrd == r) return 2'b10;
    if (wrw && wrd == r) return 2'b01;
    if (hv && hr == r) return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    e_fwd = '0; e_store = 1'b0; e_hold_we = 1'b0;
    e_sif = 1'b0; e_sid = 1'b0; e_sex = 1'b0; e_smem = 1'b0; e_bex = 1'b0; e_bwb = 1'b0;
    mem_busy = (mem_memread || mem_memwrite) && !mem_ready;
    e_haz = 1'b0;
    for (int i = 0; i < NUM_RS; i++)
      if (id_rs_used[i] && id_rs[i*AW +: AW] == ex_rd) e_haz = 1'b1;
    e_haz = e_haz && ex_memread && ex_regwrite && (ex_rd != '0);
    if (!rst) begin
      for (int i = 0; i < NUM_RS; i++)
        e_fwd[i*2 +: 2] = fwd_code(ex_rs[i*AW +: AW], mem_regwrite, mem_rd,
                                   wb_regwrite, wb_rd, m_hv, m_hr);
      e_store = wb_regwrite && mem_memwrite && wb_rd == mem_rs2 && mem_rs2 != '0;
      if (m_wait) begin
        e_sif = 1'b1; e_sid = 1'b1; e_sex = 1'b1; e_smem = 1'b1; e_bwb = 1'b1;
      end else if (m_lu_left > 0 || (!mem_busy && e_haz)) begin
        e_sif = 1'b1; e_sid = 1'b1; e_bex = 1'b1;
      end
      e_hold_we = e_sex && wb_regwrite && wb_rd != '0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 1'b0; m_lu_left <= 0; m_hv <= 1'b0; m_hr <= '0;
    end else begin
      if (m_wait) begin
        if (mem_ready) m_wait <= 1'b0;
      end else if (mem_busy) m_wait <= 1'b1;
      else if (m_lu_left > 0) m_lu_left <= m_lu_left - 1;
      else if (e_haz) m_lu_left <= LOAD_LAT - 1;
      if (e_hold_we) begin
        m_hv <= 1'b1; m_hr <= wb_rd;
      end else if (!m_wait) m_hv <= 1'b0;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("fwd_sel", 32'(fwd_sel), 32'(e_fwd));
      cmp("store_fwd", 32'(store_fwd), 32'(e_store));
      cmp("hold_we", 32'(hold_we), 32'(e_hold_we));
      cmp("stall_if", 32'(stall_if), 32'(e_sif));
      cmp("stall_id", 32'(stall_id), 32'(e_sid));
      cmp("stall_ex", 32'(stall_ex), 32'(e_sex));
      cmp("stall_mem", 32'(stall_mem), 32'(e_smem));
      cmp("bubble_ex", 32'(bubble_ex), 32'(e_bex));
      cmp("bubble_wb", 32'(bubble_wb), 32'(e_bwb));
    end
  end

  task automatic idle();
    id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0; mem_memwrite = 1'b0; mem_rs2 = '0;
    mem_ready = 1'b1; wb_rd = '0; wb_regwrite = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NUM_RS; i++) begin
      id_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
      ex_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
    end
    id_rs_used   = NUM_RS'($urandom);
    ex_rd        = AW'($urandom_range(0, 7));
    ex_regwrite  = ($urandom_range(0, 3) != 0);
    ex_memread   = ($urandom_range(0, 2) == 0);
    mem_rd       = AW'($urandom_range(0, 7));
    mem_regwrite = ($urandom_range(0, 1) == 0);
    mem_memread  = ($urandom_range(0, 3) == 0);
    mem_memwrite = ($urandom_range(0, 3) == 0);
    mem_rs2      = AW'($urandom_range(0, 7));
    mem_ready    = ($urandom_range(0, 3) != 0);
    wb_rd        = AW'($urandom_range(0, 7));
    wb_regwrite  = ($urandom_range(0, 1) == 0);
  endtask

  initial begin
    logic [8:0] bex_seq, bwb_seq, smem_seq;
    logic [5:0] sif_seq, bx3_seq;
    idle();
    chk_en = 1'b1;
    // Outputs forced quiet while reset is held, even with hazards present
    ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3; id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
    mid();
    cmp("rst_fwd_sel", 32'(fwd_sel), 32'h0);
    cmp("rst_bubble_ex", 32'(bubble_ex), 32'h0);
    idle();
    rst = 1'b0;

    // 1: MEM beats WB; WB alone gives 01
    step(); idle();
    ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
    mid(); cmp("t1_mem_wins", 32'(fwd_sel), 32'h2);
    step(); mem_regwrite = 1'b0;
    mid(); cmp("t1_wb_only", 32'(fwd_sel), 32'h1);

    // 2: x0 never forwards; store data bypass when names match
    step(); idle();
    mem_regwrite = 1'b1; mem_memwrite = 1'b1; wb_regwrite = 1'b1;
    mid(); cmp("t2_x0_fwd", 32'(fwd_sel), 32'h0); cmp("t2_x0_store", 32'(store_fwd), 32'h0);
    step(); mem_rs2 = 5'd4; wb_rd = 5'd4;
    mid(); cmp("t2_store_fwd", 32'(store_fwd), 32'h1);

    // 3: load-use with LOAD_LAT=3 -> three stall/bubble cycles
    step(); idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    sif_seq = '0; bx3_seq = '0;
    for (int k = 0; k < 6; k++) begin
      mid(); sif_seq[k] = stall_if; bx3_seq[k] = bubble_ex;
      step(); ex_memread = 1'b0;
    end
    cmp("t3_stall_if_seq", 32'(sif_seq), 32'h07);
    cmp("t3_bubble_ex_seq", 32'(bx3_seq), 32'h07);

    // 4: memory wait inside load-use stall freezes the remaining bubbles
    idle();
    id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10; ex_regwrite = 1'b1; ex_rd = 5'd7;
    bex_seq = '0; bwb_seq = '0; smem_seq = '0;
    for (int k = 0; k < 9; k++) begin
      ex_memread  = (k == 0);
      mem_memread = (k >= 1 && k <= 5);
      mem_ready   = !(k >= 1 && k <= 4);
      mid(); bex_seq[k] = bubble_ex; bwb_seq[k] = bubble_wb; smem_seq[k] = stall_mem;
      step();
    end
    cmp("t4_bubble_ex_seq", 32'(bex_seq), 32'h0C3);
    cmp("t4_bubble_wb_seq", 32'(bwb_seq), 32'h03C);
    cmp("t4_stall_mem_seq", 32'(smem_seq), 32'h03C);

    // 5: write retired during EX freeze is served from the hold register
    idle(); mem_memread = 1'b1; mem_ready = 1'b0;
    step(); mem_ready = 1'b1; wb_rd = 5'd9; wb_regwrite = 1'b1;
    mid(); cmp("t5_hold_we", 32'(hold_we), 32'h1);
    step(); idle(); ex_rs = {5'd9, 5'd0};
    mid(); cmp("t5_fwd_hold", 32'(fwd_sel), 32'hC);
    step();
    mid(); cmp("t5_hold_cleared", 32'(fwd_sel), 32'h0);

    // 6: asynchronous reset in the middle of a memory wait
    step(); idle(); mem_memread = 1'b1; mem_ready = 1'b0;
    step();
    mid(); cmp("t6_in_wait", 32'(stall_ex), 32'h1);
    #2 rst = 1'b1;
    #1 cmp("t6_async_stall_if", 32'(stall_if), 32'h0);
    cmp("t6_async_stall_mem", 32'(stall_mem), 32'h0);
    cmp("t6_async_bubble_wb", 32'(bubble_wb), 32'h0);
    idle();
    @(negedge clk); #2 rst = 1'b0;
    step();
    mid(); cmp("t6_run_stall_mem", 32'(stall_mem), 32'h0); cmp("t6_run_bubble_wb", 32'(bubble_wb), 32'h0);
    step(); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd2; id_rs = {5'd0, 5'd2}; id_rs_used = 2'b01;
    mid(); cmp("t6_run_loaduse", 32'(bubble_ex), 32'h1);

    // Randomized traffic against the model
    repeat (3000) begin
      step(); rand_inputs();
    end
    step(); idle();
    repeat (4) step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
